// File: rtl/mf_pkg.sv
// Shared constants, FSM state encoding and Q15 saturation helper for the
// matched-filter MAC.
package mf_pkg;

   localparam int MF_TAPS  = 60;
   localparam int MF_DW    = 16;
   localparam int MF_ACC_W = 40;

   localparam logic signed [MF_ACC_W-1:0] Q15_MAX = 40'sd32767;
   localparam logic signed [MF_ACC_W-1:0] Q15_MIN = -40'sd32768;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } mf_state_e;

   // Arithmetic shift back to Q15 (truncating) and clamp to the 16-bit range.
   function automatic logic signed [MF_DW-1:0] sat_q15(input logic signed [MF_ACC_W-1:0] acc);
      logic signed [MF_ACC_W-1:0] shifted;
      logic signed [MF_DW-1:0]    res;
      shifted = acc >>> 5'd15;
      if (shifted > Q15_MAX) begin
         res = 16'sh7FFF;
      end else if (shifted < Q15_MIN) begin
         res = 16'sh8000;
      end else begin
         res = shifted[MF_DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/mf_serial_mac_if.sv
// Sample stream, coefficient-ROM port and result port of the serial MAC.
// slave = the MAC itself, master = sample source / ROM / result consumer.
interface mf_serial_mac_if
   import mf_pkg::*;
#(
   parameter int DW    = MF_DW,
   parameter int ACC_W = MF_ACC_W
);
   logic                    in_valid;
   logic signed [DW-1:0]    in_data;
   logic                    in_ready;
   logic                    coef_en;
   logic [31:0]             coef_addr;
   logic signed [DW-1:0]    coef_data;
   logic                    out_valid;
   logic signed [ACC_W-1:0] out_data;
   logic signed [DW-1:0]    out_q15;

   modport slave (
      input  in_valid, in_data, coef_data,
      output in_ready, coef_en, coef_addr, out_valid, out_data, out_q15
   );

   modport master (
      output in_valid, in_data, coef_data,
      input  in_ready, coef_en, coef_addr, out_valid, out_data, out_q15
   );
endinterface

// File: rtl/mf_sample_buffer.sv
// Circular history of the last TAPS samples: one write port that advances a
// wrapping write pointer, and a registered read port so the sample lines up
// with the one-cycle ROM latency.
module mf_sample_buffer
   import mf_pkg::*;
#(
   parameter int TAPS = MF_TAPS,
   parameter int DW   = MF_DW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic signed [DW-1:0]        wdata,
   input  logic [$clog2(TAPS)-1:0]     rd_idx,
   output logic signed [DW-1:0]        rdata,
   output logic [$clog2(TAPS)-1:0]     wr_ptr
);
   localparam int AW = $clog2(TAPS);

   logic signed [DW-1:0] mem_r [TAPS];
   logic [AW-1:0]        wr_ptr_r;
   logic signed [DW-1:0] rdata_r;

   // Sample storage; contents deliberately not reset (masked by fill count).
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Write pointer advances per stored sample and wraps at TAPS-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
      end else if (we) begin
         wr_ptr_r <= (wr_ptr_r == AW'(TAPS-1)) ? '0 : wr_ptr_r + AW'(1);
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_r <= '0;
      end else begin
         rdata_r <= mem_r[rd_idx];
      end
   end

   assign rdata  = rdata_r;
   assign wr_ptr = wr_ptr_r;

endmodule

// File: rtl/mf_serial_mac.sv
// Time-multiplexed matched filter: per accepted sample, sweeps the coefficient
// ROM over TAPS addresses and accumulates h[k]*x[n-k] into one output.
module mf_serial_mac
   import mf_pkg::*;
#(
   parameter int TAPS  = MF_TAPS,
   parameter int DW    = MF_DW,
   parameter int ACC_W = MF_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   mf_serial_mac_if.slave    bus
);
   localparam int AW = $clog2(TAPS);
   localparam int FW = $clog2(TAPS + 1);

   mf_state_e               state_r;
   logic                    in_ready_r;
   logic                    coef_en_r;
   logic [AW-1:0]           k_r;
   logic [AW-1:0]           rd_idx_r;
   logic [FW-1:0]           fill_r;
   logic                    en_d_r;
   logic [AW-1:0]           tap_d_r;
   logic signed [ACC_W-1:0] acc_r;
   logic                    out_valid_r;
   logic signed [ACC_W-1:0] out_data_r;
   logic signed [DW-1:0]    out_q15_r;

   logic                    accept_s;
   logic [AW-1:0]           wr_ptr_s;
   logic signed [DW-1:0]    rd_data_s;
   logic signed [2*DW-1:0]  prod_s;
   logic signed [ACC_W-1:0] acc_nxt_s;
   logic [31:0]             tap_ext_s;
   logic [31:0]             fill_ext_s;

   assign accept_s   = (state_r == IDLE) && in_ready_r && bus.in_valid;
   assign tap_ext_s  = {{(32-AW){1'b0}}, tap_d_r};
   assign fill_ext_s = {{(32-FW){1'b0}}, fill_r};

   mf_sample_buffer #(.TAPS(TAPS), .DW(DW)) u_buf (
      .clk    (clk),
      .rst    (rst),
      .we     (accept_s),
      .wdata  (bus.in_data),
      .rd_idx (rd_idx_r),
      .rdata  (rd_data_s),
      .wr_ptr (wr_ptr_s)
   );

   // Product of the delayed tap; taps beyond the current history count as zero,
   // and coef_data is only looked at in the cycle after a ROM enable.
   always_comb begin
      prod_s = '0;
      if (en_d_r && (tap_ext_s < fill_ext_s)) begin
         prod_s = $signed({{DW{bus.coef_data[DW-1]}}, bus.coef_data})
                * $signed({{DW{rd_data_s[DW-1]}}, rd_data_s});
      end else begin
         prod_s = '0;
      end
      acc_nxt_s = acc_r + $signed({{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s});
   end

   // Delay enable and tap index by one cycle to match ROM read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_d_r  <= 1'b0;
         tap_d_r <= '0;
      end else begin
         en_d_r  <= coef_en_r;
         tap_d_r <= k_r;
      end
   end

   // Control FSM with accumulator, fill counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b0;
         coef_en_r   <= 1'b0;
         k_r         <= '0;
         rd_idx_r    <= '0;
         fill_r      <= '0;
         acc_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_q15_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               out_valid_r <= 1'b0;
               if (accept_s) begin
                  state_r    <= MAC;
                  in_ready_r <= 1'b0;
                  coef_en_r  <= 1'b1;
                  k_r        <= '0;
                  rd_idx_r   <= wr_ptr_s;
                  acc_r      <= '0;
                  fill_r     <= (fill_r == FW'(TAPS)) ? fill_r : fill_r + FW'(1);
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            MAC: begin
               acc_r <= acc_nxt_s;
               if (k_r == AW'(TAPS-1)) begin
                  coef_en_r <= 1'b0;
                  state_r   <= DRAIN;
               end else begin
                  k_r      <= k_r + AW'(1);
                  rd_idx_r <= (rd_idx_r == '0) ? AW'(TAPS-1) : rd_idx_r - AW'(1);
               end
            end
            DRAIN: begin
               acc_r       <= acc_nxt_s;
               out_data_r  <= acc_nxt_s;
               out_q15_r   <= sat_q15(acc_nxt_s);
               out_valid_r <= 1'b1;
               state_r     <= OUT;
            end
            OUT: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               k_r         <= '0;
               state_r     <= IDLE;
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               coef_en_r   <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.coef_en   = coef_en_r;
   assign bus.coef_addr = {{(32-AW){1'b0}}, k_r};
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_q15   = out_q15_r;

endmodule

// File: tb/tb_mf_serial_mac.sv
// Directed bench for mf_serial_mac: ROM model that floats its bus when idle,
// streaming driver with handshake timing checks and a convolution reference.
module tb_mf_serial_mac;

   logic clk;
   logic rst;

   mf_serial_mac_if bus ();

   mf_serial_mac dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     n_tests = 0;
   int     n_fail  = 0;
   int     h [60];
   int     hist [$];
   int     stim [$];
   longint outs [$];
   longint outq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint model_y();
      longint s;
      int     len;
      s   = 0;
      len = hist.size();
      for (int k = 0; k < 60 && k < len; k++) begin
         s += longint'(h[k]) * longint'(hist[len-1-k]);
      end
      return s;
   endfunction

   function automatic longint sat_m(input longint y);
      longint s;
      s = y >>> 15;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // Coefficient ROM: data one cycle after enable, X or Z otherwise.
   initial begin
      logic        en_l;
      logic [31:0] addr_l;
      bit          tog;
      tog = 1'b0;
      bus.coef_data = 16'bz;
      forever begin
         @(negedge clk);
         en_l   = bus.coef_en;
         addr_l = bus.coef_addr;
         @(posedge clk);
         #1;
         if (en_l && addr_l < 32'd60) begin
            bus.coef_data = 16'(h[addr_l]);
         end else begin
            bus.coef_data = tog ? 16'bx : 16'bz;
            tog = ~tog;
         end
      end
   end

   // Streams n samples from stim with in_valid held high, checking timing and results.
   task automatic run_stream(input int n);
      int acc_cnt, outs_cnt, last_acc, low_run, en_run, addr_bad, cyc;
      longint e;
      acc_cnt = 0; outs_cnt = 0; last_acc = -1; low_run = 0;
      en_run = 0; addr_bad = 0; cyc = 0;
      outs.delete();
      outq.delete();
      bus.in_valid = 1'b1;
      while (outs_cnt < n && cyc < n * 63 + 100) begin
         if (bus.out_valid) begin
            e = model_y();
            chk("out_data", bus.out_data, e);
            chk("out_q15", bus.out_q15, sat_m(e));
            chk("out_known", 64'($isunknown(bus.out_data)), 64'd0);
            outs.push_back(longint'(bus.out_data));
            outq.push_back(longint'(bus.out_q15));
            outs_cnt++;
         end
         if (bus.in_ready) begin
            if (last_acc >= 0) begin
               chk("accept_period", cyc - last_acc, 63);
               chk("ready_low_run", low_run, 62);
            end
            last_acc = cyc;
            low_run  = 0;
            if (acc_cnt < n) begin
               bus.in_data = 16'(stim[acc_cnt]);
               hist.push_back(stim[acc_cnt]);
               acc_cnt++;
            end
         end else begin
            low_run++;
            bus.in_data = 16'($urandom);
         end
         if (bus.coef_en) begin
            if (bus.coef_addr != 32'(en_run)) addr_bad++;
            en_run++;
         end else if (en_run > 0) begin
            chk("coef_en_run", en_run, 60);
            chk("coef_addr_order", addr_bad, 0);
            en_run   = 0;
            addr_bad = 0;
         end
         if (outs_cnt < n) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (outs_cnt < n) chk("stream_timeout", outs_cnt, n);
      bus.in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  bus.in_ready, 0);
      chk({tag, "_coef_en"},   bus.coef_en, 0);
      chk({tag, "_coef_addr"}, bus.coef_addr, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"},  bus.out_data, 0);
      chk({tag, "_out_q15"},   bus.out_q15, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'sd0;
      h[0] = 32767;
      h[1] = 32763;
      for (int k = 2; k < 60; k++) begin
         h[k] = $rtoi(32767.0 * $cos(3.14159265 * k * k / 120.0));
      end
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b1;

      // Impulse: outputs trace the coefficients, then x0 leaves the window.
      stim.delete();
      stim.push_back(32767);
      for (int i = 0; i < 60; i++) stim.push_back(0);
      run_stream(61);
      chk("pulse_one_cycle", bus.out_valid, 0);
      chk("imp_y0", outs[0], 64'sd1073676289);
      chk("imp_q0", outq[0], 64'sd32766);
      chk("imp_y1", outs[1], 64'sd1073545221);
      chk("imp_q1", outq[1], 64'sd32762);
      for (int k = 0; k < 60; k++) chk("imp_hk", outs[k], 64'(32767 * longint'(h[k])));
      chk("imp_tail", outs[60], 0);

      // Saturation of out_q15 on a large negative sum.
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      hist.delete();
      stim.delete();
      stim.push_back(-32768);
      stim.push_back(-32768);
      run_stream(2);
      chk("sat_q0", outq[0], -64'sd32767);
      chk("sat_y1", outs[1], -64'sd2147287040);
      chk("sat_q1", outq[1], -64'sd32768);
      chk("sat_hold", bus.out_data, -64'sd2147287040);

      // Long random run across pointer wrap and full history.
      stim.delete();
      for (int i = 0; i < 200; i++) stim.push_back(int'($urandom_range(65535)) - 32768);
      run_stream(200);

      // Reset in the middle of a sweep.
      chk("mid_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd1234;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (29) @(negedge clk);
      chk("mid_coef_en", bus.coef_en, 1);
      chk("mid_coef_addr", bus.coef_addr, 29);
      rst = 1'b0;
      #1;
      check_reset_outputs("mid");
      @(negedge clk);
      rst = 1'b1;
      hist.delete();
      stim.delete();
      stim.push_back(32767);
      run_stream(1);
      chk("post_rst_q0", outq[0], 64'sd32766);
      chk("post_rst_y0", outs[0], 64'sd1073676289);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
